// File: rtl/wb_stage_pkg.sv
// Shared widths and types for the writeback stage: register-file geometry,
// load-buffer depth and the write-port source selector.
package wb_stage_pkg;

  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_NREG       = 32;
  localparam int WB_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_FIFO = 2'd2
  } wr_src_e;

endpackage

// File: rtl/wb_stage_if.sv
// Bundle of ALU, load-issue, load-response and register-file signals around
// the writeback stage. The stage uses the slave view; its environment uses master.
interface wb_stage_if
  import wb_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int NREG       = WB_NREG
) ();

  logic                  alu_valid;
  logic                  alu_ready;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;

  logic                  ld_issue;
  logic [ADDR_WIDTH-1:0] ld_issue_rd;

  logic                  ld_rsp_valid;
  logic                  ld_rsp_ready;
  logic [ADDR_WIDTH-1:0] ld_rsp_rd;
  logic [DATA_WIDTH-1:0] ld_rsp_data;

  logic                  wrt_en;
  logic [ADDR_WIDTH-1:0] addrD;
  logic [DATA_WIDTH-1:0] d;
  logic [NREG-1:0]       busy;
  logic                  waw_err;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue, ld_issue_rd,
    output ld_rsp_valid, ld_rsp_rd, ld_rsp_data,
    input  alu_ready, ld_rsp_ready,
    input  wrt_en, addrD, d, busy, waw_err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue, ld_issue_rd,
    input  ld_rsp_valid, ld_rsp_rd, ld_rsp_data,
    output alu_ready, ld_rsp_ready,
    output wrt_en, addrD, d, busy, waw_err
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular synchronous FIFO with registered count; the head entry is always
// visible on rdata_o so a pop and its data use the same edge.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && empty_o));
  a_no_overflow  : assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o));

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: merges ALU results and buffered load responses onto the
// single register-file write port and tracks registers with loads in flight.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int NREG       = WB_NREG,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input logic       clk,
  input logic       rst_n,
  wb_stage_if.slave bus
);

  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

  logic                  fifo_full;
  logic                  fifo_full_flag;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [ENTRY_W-1:0]    fifo_head;
  logic [ADDR_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  alu_xfer;
  logic                  ld_xfer;
  logic                  fifo_pop;
  wr_src_e               wr_src;

  logic                  wrt_en_q, wrt_en_d;
  logic [ADDR_WIDTH-1:0] addrD_q, addrD_d;
  logic [DATA_WIDTH-1:0] d_q, d_d;
  logic [NREG-1:0]       busy_q, busy_d;
  logic                  waw_q, waw_d;

  // Both readies come from the registered count only, never from the valids.
  assign fifo_full        = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign bus.alu_ready    = !fifo_full;
  assign bus.ld_rsp_ready = !fifo_full;
  assign alu_xfer         = bus.alu_valid && !fifo_full;
  assign ld_xfer          = bus.ld_rsp_valid && !fifo_full;
  assign {head_rd, head_data} = fifo_head;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (ld_xfer),
    .pop_i   (fifo_pop),
    .wdata_i ({bus.ld_rsp_rd, bus.ld_rsp_data}),
    .rdata_o (fifo_head),
    .full_o  (fifo_full_flag),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // A full buffer drains first; otherwise the ALU wins and loads wait.
  always_comb begin
    wr_src = SRC_NONE;
    if (fifo_full_flag) begin
      wr_src = SRC_FIFO;
    end else if (alu_xfer) begin
      wr_src = SRC_ALU;
    end else if (!fifo_empty) begin
      wr_src = SRC_FIFO;
    end
  end

  assign fifo_pop = (wr_src == SRC_FIFO);

  always_comb begin
    wrt_en_d = 1'b0;
    addrD_d  = addrD_q;
    d_d      = d_q;
    busy_d   = busy_q;
    waw_d    = alu_xfer && busy_q[bus.alu_rd];
    case (wr_src)
      SRC_ALU: begin
        wrt_en_d = 1'b1;
        addrD_d  = bus.alu_rd;
        d_d      = bus.alu_data;
      end
      SRC_FIFO: begin
        wrt_en_d        = 1'b1;
        addrD_d         = head_rd;
        d_d             = head_data;
        busy_d[head_rd] = 1'b0;
      end
      default: ;
    endcase
    // Applied after the clear so a same-edge reissue keeps the register busy.
    if (bus.ld_issue) begin
      busy_d[bus.ld_issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrt_en_q <= 1'b0;
      addrD_q  <= '0;
      d_q      <= '0;
      busy_q   <= '0;
      waw_q    <= 1'b0;
    end else begin
      wrt_en_q <= wrt_en_d;
      addrD_q  <= addrD_d;
      d_q      <= d_d;
      busy_q   <= busy_d;
      waw_q    <= waw_d;
    end
  end

  assign bus.wrt_en  = wrt_en_q;
  assign bus.addrD   = addrD_q;
  assign bus.d       = d_q;
  assign bus.busy    = busy_q;
  assign bus.waw_err = waw_q;

endmodule
